// File: rtl/seradd_pkg.sv
// Shared definitions for the nibble-serial adder: cell width, FSM states and
// the nibble index counter width.
package seradd_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } seradd_state_t;

    // Index counter width; a single-nibble adder still needs one bit.
    function automatic int cnt_width(input int nibbles);
        return (nibbles <= 1) ? 1 : $clog2(nibbles);
    endfunction

endpackage

// File: rtl/rca4.sv
// Combinational 4-bit ripple-carry adder cell built from per-bit
// generate/propagate terms.
module rca4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [3:0] g;
    logic [3:0] p;
    logic       c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        c = ci;
        s = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            s[i] = p[i] ^ c;
            c    = g[i] | (p[i] & c);
        end
        co = c;
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that sequences operands one nibble per clock through a single rca4.
// Define SERADD_SUB_EN to add the sub port (a - b via inverted b and carry-in 1).
module nibble_serial_adder
    import seradd_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NIB_W*NIBBLES-1:0] a,
    input  logic [NIB_W*NIBBLES-1:0] b,
    input  logic                     cin,
`ifdef SERADD_SUB_EN
    input  logic                     sub,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NIB_W*NIBBLES-1:0] sum,
    output logic                     cout,
    output logic                     busy
);

    localparam int W     = NIB_W * NIBBLES;
    localparam int CNT_W = cnt_width(NIBBLES);

    seradd_state_t    state_r, state_nxt;
    logic [CNT_W-1:0] idx_r;
    logic [W-1:0]     a_r;
    logic [W-1:0]     b_r;
    logic [W-1:0]     sum_r;
    logic             carry_r;
    logic             cout_r;
    logic             last_nib;

    logic [NIB_W-1:0] a_nib;
    logic [NIB_W-1:0] b_nib;
    logic [NIB_W-1:0] b_cell;
    logic [NIB_W-1:0] cell_s;
    logic             cell_co;
    logic             carry_init;

`ifdef SERADD_SUB_EN
    logic sub_r;
    assign b_cell     = b_nib ^ {NIB_W{sub_r}};
    assign carry_init = sub ? 1'b1 : cin;
`else
    assign b_cell     = b_nib;
    assign carry_init = cin;
`endif

    assign last_nib  = (idx_r == CNT_W'(NIBBLES - 1));
    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign busy      = (state_r != IDLE);
    assign sum       = sum_r;
    assign cout      = cout_r;

    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (idx_r == CNT_W'(i)) begin
                a_nib = a_r[i*NIB_W +: NIB_W];
                b_nib = b_r[i*NIB_W +: NIB_W];
            end
        end
    end

    rca4 u_cell (
        .a  (a_nib),
        .b  (b_cell),
        .ci (carry_r),
        .s  (cell_s),
        .co (cell_co)
    );

    always_comb begin
        state_nxt = state_r;
        case (state_r)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last_nib)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r   <= '0;
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
`ifdef SERADD_SUB_EN
            sub_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= a;
                        b_r     <= b;
                        idx_r   <= '0;
                        carry_r <= carry_init;
`ifdef SERADD_SUB_EN
                        sub_r   <= sub;
`endif
                    end
                end
                RUN: begin
                    for (int unsigned i = 0; i < NIBBLES; i++) begin
                        if (idx_r == CNT_W'(i)) sum_r[i*NIB_W +: NIB_W] <= cell_s;
                    end
                    carry_r <= cell_co;
                    // Index holds on the last nibble so it never exceeds NIBBLES-1.
                    if (last_nib) cout_r <= cell_co;
                    else          idx_r  <= idx_r + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle wide adder that sequences two `4*NIBBLES`-bit operands through a single 4-bit ripple-carry adder cell, one nibble per clock, least-significant first. A carry register links the nibbles. The block sits directly upstream of the 4-bit adder datapath: it drives that cell's operands and carry-in, and collects its sum and carry-out into a wide result. Ready/valid handshakes on both sides let it sit between an operand source and a result consumer.

## Interface
- `NIBBLES`, default 4: number of 4-bit nibbles per operand. Legal range is 1–16.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operands `a`, `b`, `cin` are valid.
- `in_ready`  out  1  block can accept operands.
- `a`  in  `4*NIBBLES`  operand A.
- `b`  in  `4*NIBBLES`  operand B.
- `cin`  in  1  carry into nibble 0.
- `sub`  in  1  subtract select. Present only when `SERADD_SUB_EN` is defined.
- `out_valid`  out  1  `sum`/`cout` hold a completed result.
- `out_ready`  in  1  consumer accepts the result.
- `sum`  out  `4*NIBBLES`  registered result.
- `cout`  out  1  registered carry out of the top nibble.
- `busy`  out  1  high in RUN or DONE.

## Operation
- FSM states are IDLE, RUN and DONE. Reset enters IDLE.
- **IDLE**
  - `in_ready=1`.
  - On `in_valid && in_ready`, the block latches `a`, `b` and `cin` (and `sub`) into operand registers.
  - It clears the nibble index to 0, loads the carry register with `cin`, and moves to RUN.
- **RUN**
  - Each cycle the adder cell receives `a_r[4i+3:4i]`, `b_r[4i+3:4i]` and `carry_r`.
  - The 4-bit cell sum is written to `sum_r[4i+3:4i]`, and the cell carry-out goes to `carry_r`. Then `i` increments.
  - After nibble `NIBBLES-1` is written, `cout` takes the final carry and the FSM moves to DONE.
- **DONE**
  - `out_valid=1`. `sum` and `cout` are held stable.
  - On `out_ready`, the FSM returns to IDLE.
- Arithmetic
  - The result is exactly `{cout,sum} = a + b + cin`, modulo `2^(4*NIBBLES+1)`.
  - The index counter is `$clog2(NIBBLES)` bits wide, with a minimum of 1. It never wraps past `NIBBLES-1`.
- Outputs
  - `sum` and `cout` change only while in RUN. Higher nibbles of `sum` keep their previous values until they are overwritten.
  - Consumers must use `sum` only while `out_valid=1`.
- Boundary conditions
  - `in_valid` is ignored outside IDLE. There is no queuing.
  - `out_ready` asserted before DONE has no effect.
  - `NIBBLES=1`: RUN lasts exactly one cycle.
  - Reset asserted mid-RUN or mid-DONE forces IDLE immediately and discards the partial result.

## Timing
- Reset values:
  - `in_ready=1`
  - `out_valid=0`
  - `busy=0`
  - `sum=0`
  - `cout=0`
  - internal registers are all 0
- Acceptance edge is cycle 0. RUN occupies cycles 1 through `NIBBLES`. `out_valid` rises at cycle `NIBBLES+1`.
- Minimum input-to-input spacing is `NIBBLES+2` cycles, counted with `out_ready` held high.
- `in_ready` is combinational from state: it equals `state==IDLE`.
- `out_valid` is combinational from state: it equals `state==DONE`.
- Neither has a combinational path from any input.
- The 4-bit cell is purely combinational and lies between registers. It must close timing within one cycle.

## Configuration
- `SERADD_SUB_EN` defined:
  - The `sub` port exists and is latched with the operands.
  - When `sub=1`, each `b` nibble is inverted before entering the cell and the carry register loads 1. The `cin` input is ignored.
  - Result is `sum = a - b` modulo `2^(4*NIBBLES)`, with `cout=1` meaning no borrow.
- `SERADD_SUB_EN` undefined:
  - There is no `sub` port and no inversion logic. The block only adds.

## Structure
- `seradd_pkg` holds:
  - `NIB_W = 4`
  - the state enum `seradd_state_t` (IDLE, RUN, DONE)
  - a function giving the index counter width
- One sub-module, `rca4`:
  - 4-bit ripple-carry adder with ports `a[3:0]`, `b[3:0]`, `ci`, `s[3:0]`, `co`.
  - Built from per-bit generate/propagate terms.
  - Instantiated once.

## Test plan
All scenarios use `NIBBLES=4` unless noted.
- `a=0x1234`, `b=0x0FFF`, `cin=0` → `sum=0x2233`, `cout=0`. `out_valid` rises exactly 5 cycles after acceptance.
- `a=0xFFFF`, `b=0x0001`, `cin=0` → `sum=0x0000`, `cout=1`. The carry ripples through all 4 nibbles. Also `a=0`, `b=0`, `cin=1` → `sum=0x0001`.
- Back-pressure: hold `out_ready=0` for 10 cycles in DONE.
  - `sum`/`cout` must stay stable and `in_ready=0`.
  - A new `in_valid` pulse during that time is ignored.
  - Raising `out_ready` returns the block to IDLE the next cycle.
- Reset mid-operation: assert `rst_n=0` at RUN cycle 2 → all outputs take their reset values immediately, with no spurious `out_valid`. A following operation gives the correct result.
- With `SERADD_SUB_EN`:
  - `sub=1`, `a=0x0005`, `b=0x0007` → `sum=0xFFFE`, `cout=0`.
  - `a=0x0007`, `b=0x0005` → `sum=0x0002`, `cout=1`.
- Randomised sweep over 1000 operand pairs at `NIBBLES=1` and `NIBBLES=16`, checked against the reference sum `a+b+cin`.
